// File: rtl/polyshift_seq_pkg.sv
// Shared types and constants for the multi-cycle polyshift sequencer and its
// combinational datapath.
package polyshift_seq_pkg;

  typedef enum logic [1:0] {
    LOGIC = 2'd0,
    ARITH = 2'd1,
    RCR   = 2'd2,
    ROR   = 2'd3
  } shift_type_t;

  // Largest distance the datapath is asked to move in one sequencer cycle.
  localparam int POLYSHIFT_MAX_STEP = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/polyshift_seq_if.sv
// Request/response bundle between a client (master) and polyshift_seq (slave).
interface polyshift_seq_if #(
  parameter int WORD_WIDTH = 16
);
  import polyshift_seq_pkg::*;

  localparam int SW = $clog2(WORD_WIDTH);

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [WORD_WIDTH-1:0] d_i;
  logic [WORD_WIDTH-2:0] c_i;
  logic [SW-1:0]         shift_size_i;
  shift_type_t           shift_type_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [WORD_WIDTH-1:0] d_o;
  logic                  busy_o;

  modport master (
    output req_valid_i, d_i, c_i, shift_size_i, shift_type_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, d_o, busy_o
  );

  modport slave (
    input  req_valid_i, d_i, c_i, shift_size_i, shift_type_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, d_o, busy_o
  );

endinterface

// File: rtl/polyshift_r.sv
// Combinational single-pass shifter: logical, arithmetic, rotate, and
// rotate-through a (WORD_WIDTH-1)-bit carry word.
module polyshift_r
  import polyshift_seq_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  localparam int SW = $clog2(WORD_WIDTH)
) (
  input  shift_type_t           shift_type_i,
  input  logic [WORD_WIDTH-1:0] d_i,
  input  logic [WORD_WIDTH-2:0] c_i,
  input  logic [SW-1:0]         shift_size_i,
  output logic [WORD_WIDTH-1:0] d_o
);

  logic [2*WORD_WIDTH-1:0] rot_full;
  logic [2*WORD_WIDTH-2:0] rcr_full;

  // Rotations are plain right shifts of a doubled vector; the low word is kept.
  assign rot_full = {d_i, d_i} >> shift_size_i;
  assign rcr_full = {c_i, d_i} >> shift_size_i;

  always_comb begin
    d_o = d_i >> shift_size_i;
    case (shift_type_i)
      LOGIC:   d_o = d_i >> shift_size_i;
      ARITH:   d_o = $signed(d_i) >>> shift_size_i;
      RCR:     d_o = rcr_full[WORD_WIDTH-1:0];
      ROR:     d_o = rot_full[WORD_WIDTH-1:0];
      default: d_o = d_i >> shift_size_i;
    endcase
  end

endmodule

// File: rtl/polyshift_seq.sv
// Multi-cycle shifter: splits a shift of up to WORD_WIDTH-1 positions into
// steps of at most POLYSHIFT_MAX_STEP through one polyshift_r instance.
module polyshift_seq
  import polyshift_seq_pkg::*;
#(
  parameter int WORD_WIDTH = 16
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  polyshift_seq_if.slave bus
);

  localparam int SW = $clog2(WORD_WIDTH);
  localparam logic [SW-1:0] MAX_STEP = SW'(POLYSHIFT_MAX_STEP);

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] d_q, d_d;
  logic [WORD_WIDTH-2:0] c_q, c_d;
  logic [SW-1:0]         rem_q, rem_d;
  shift_type_t           type_q, type_d;

  logic [SW-1:0]         step;
  logic [WORD_WIDTH-1:0] shift_res;

  polyshift_r #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_polyshift_r (
    .shift_type_i (type_q),
    .d_i          (d_q),
    .c_i          (c_q),
    .shift_size_i (step),
    .d_o          (shift_res)
  );

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    c_d     = c_q;
    rem_d   = rem_q;
    type_d  = type_q;
    step    = (rem_q > MAX_STEP) ? MAX_STEP : rem_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          d_d     = bus.d_i;
          c_d     = bus.c_i;
          rem_d   = bus.shift_size_i;
          type_d  = bus.shift_type_i;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        d_d   = shift_res;
        rem_d = rem_q - step;
        // The carry word drains alongside D so the next step sees fresh bits.
        if (type_q == RCR) begin
          c_d = c_q >> step;
        end
        if (rem_q == step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      d_q     <= '0;
      c_q     <= '0;
      rem_q   <= '0;
      type_q  <= LOGIC;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      c_q     <= c_d;
      rem_q   <= rem_d;
      type_q  <= type_d;
    end
  end

  // Ready is gated by reset so nothing advertises acceptance while held in reset.
  assign bus.req_ready_o = (state_q == IDLE) && rst_n_i;
  assign bus.rsp_valid_o = (state_q == DONE);
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.d_o         = d_q;

endmodule

// File: tb/tb_polyshift_seq.sv
// Directed and randomized checks of polyshift_seq against an arithmetic
// single-pass shift model and a ceil(n/7) latency model.
module tb_polyshift_seq;
  import polyshift_seq_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  polyshift_seq_if #(.WORD_WIDTH(W)) bus ();

  polyshift_seq #(.WORD_WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input int t, input logic [W-1:0] d,
                                         input logic [W-2:0] c, input int n);
    longint sd;
    longint unsigned cd;
    case (t)
      0: return d >> n;
      1: begin
        sd = d[W-1] ? longint'(d) - (longint'(1) << W) : longint'(d);
        return W'(sd >>> n);
      end
      2: begin
        cd = (longint'(c) << W) + longint'(d);
        return W'(cd >> n);
      end
      default: return W'((longint'(d) >> n) | (longint'(d) << (W - n)));
    endcase
  endfunction

  function automatic int model_lat(input int n);
    return (n == 0) ? 1 : (n + 6) / 7;
  endfunction

  // One full transaction: accept, time the response, hold it for `gap`
  // cycles with a stray request, then complete the handshake.
  task automatic run_op(input int t, input logic [W-1:0] d, input logic [W-2:0] c,
                        input int n, input int gap, input bit chk_mid,
                        input logic [W-1:0] mid);
    logic [W-1:0] exp;
    int cyc;
    exp = model(t, d, c, n);
    @(negedge clk);
    bus.req_valid_i  = 1'b1;
    bus.d_i          = d;
    bus.c_i          = c;
    bus.shift_size_i = 4'(n);
    bus.shift_type_i = shift_type_t'(t);
    check("req_ready_idle", 32'(bus.req_ready_o), 32'd1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.d_i = '0;
    check("busy_after_accept", 32'(bus.busy_o), 32'd1);
    cyc = 0;
    while (!bus.rsp_valid_o && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (chk_mid && cyc == 1) check("mid_d", 32'(bus.d_o), 32'(mid));
    end
    $display("op type=%0d d=%h c=%h n=%0d latency=%0d d_o=%h exp=%h gap=%0d",
             t, d, c, n, cyc, bus.d_o, exp, gap);
    check("latency", 32'(cyc), 32'(model_lat(n)));
    check("result", 32'(bus.d_o), 32'(exp));
    for (int g = 0; g < gap; g++) begin
      bus.req_valid_i  = 1'b1;
      bus.d_i          = W'($urandom);
      bus.shift_size_i = 4'($urandom_range(0, W - 1));
      @(posedge clk); #1;
      check("hold_d", 32'(bus.d_o), 32'(exp));
      check("hold_valid", 32'(bus.rsp_valid_o), 32'd1);
      check("hold_not_ready", 32'(bus.req_ready_o), 32'd0);
    end
    // A request overlapping the response handshake must not be taken.
    bus.req_valid_i = 1'b1;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 1'b0;
    check("post_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("post_rsp_idle", 32'(bus.req_ready_o), 32'd1);
    check("post_rsp_busy", 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    int seen_rsp;
    bus.req_valid_i  = 1'b0;
    bus.d_i          = '0;
    bus.c_i          = '0;
    bus.shift_size_i = '0;
    bus.shift_type_i = LOGIC;
    bus.rsp_ready_i  = 1'b0;

    #12;
    check("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_d_o", 32'(bus.d_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_req_ready", 32'(bus.req_ready_o), 32'd1);

    run_op(1, 16'h8001, 15'h0000, 15, 0, 1'b0, '0);
    run_op(3, 16'h0001, 15'h0000, 9, 1, 1'b0, '0);
    run_op(2, 16'h0000, 15'h7FFF, 10, 2, 1'b1, 16'hFE00);
    run_op(0, 16'hABCD, 15'h1234, 0, 5, 1'b0, '0);

    // Reset during the second SHIFT cycle of a 15-position request.
    @(negedge clk);
    bus.req_valid_i  = 1'b1;
    bus.d_i          = 16'h8001;
    bus.shift_size_i = 4'd15;
    bus.shift_type_i = ARITH;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", 32'(bus.busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(bus.req_ready_o), 32'd0);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    check("mid_rst_d_o", 32'(bus.d_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_req_ready", 32'(bus.req_ready_o), 32'd1);
    seen_rsp = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid_o) seen_rsp++;
    end
    check("post_rst_no_rsp", 32'(seen_rsp), 32'd0);
    check("post_rst_idle", 32'(bus.req_ready_o), 32'd1);

    for (int t = 0; t < 4; t++) begin
      for (int n = 0; n < W; n++) begin
        run_op(t, W'($urandom), (W-1)'($urandom), n, int'($urandom_range(0, 3)),
               1'b0, '0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/polyshift_seq.md
POLYSHIFT_SEQ -- requirements
Module: polyshift_seq

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, operand width in bits (>= 8, power of two).
REQ-002 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid_i  input  1  request valid.
REQ-005 SHALL have port req_ready_o  output  1  request accepted when both high at a clock edge.
REQ-006 SHALL have port d_i  input  WORD_WIDTH  operand.
REQ-007 SHALL have port c_i  input  WORD_WIDTH-1  double-precision carry word (RCR only).
REQ-008 SHALL have port shift_size_i  input  $clog2(WORD_WIDTH)  total shift amount, 0..WORD_WIDTH-1.
REQ-009 SHALL have port shift_type_i  input  SHIFT_TYPE  LOGIC, ARITH, RCR or ROR.
REQ-010 SHALL have port rsp_valid_o  output  1  result valid.
REQ-011 SHALL have port rsp_ready_i  input  1  result consumed when both high at a clock edge.
REQ-012 SHALL have port d_o  output  WORD_WIDTH  result.
REQ-013 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; req_ready_o = (state==IDLE), rsp_valid_o = (state==DONE).
REQ-015 On acceptance: SHALL capture d_i, c_i, shift_size_i (as remaining count), shift_type_i and go to SHIFT.
REQ-016 Each SHIFT cycle: step = min(remaining, 7); SHALL drive polyshift_r with the captured type, registered D, registered C and shift size = step.
REQ-017 Each SHIFT edge: D <= polyshift_r output; remaining <= remaining - step; for RCR, C <= C >> step (zero fill); C is unchanged for other types.
REQ-018 SHALL go SHIFT->DONE on the edge where remaining - step == 0; a request with shift_size_i=0 still spends exactly one SHIFT cycle (step 0).
REQ-019 Latency: rsp_valid_o SHALL rise max(1, ceil(n/7)) cycles after the acceptance edge, n = shift_size_i.
REQ-020 Result SHALL equal the single-pass value: LOGIC D>>n; ARITH signed D>>>n; ROR rotate D right by n; RCR low WORD_WIDTH bits of {C,D}>>n.
REQ-021 In DONE, d_o SHALL hold stable while rsp_ready_i is low; on rsp_valid_o && rsp_ready_i, SHALL go to IDLE.
REQ-022 SHALL not accept a new request in the same cycle as the response handshake; IDLE follows DONE for at least one cycle.
REQ-023 req_valid_i and operand inputs SHALL be ignored outside IDLE.
REQ-024 d_o SHALL show the registered D in every state; it is meaningful only while rsp_valid_o is high.

Reset
REQ-025 rst_n_i low SHALL immediately force state IDLE, D=0, C=0, remaining=0, type=LOGIC.
REQ-026 While rst_n_i is low, req_ready_o, rsp_valid_o and busy_o SHALL be 0 and d_o SHALL be 0.
REQ-027 Reset mid-SHIFT or mid-DONE SHALL discard the operation; no response is produced; req_ready_o=1 on the first cycle after release.

Structure
REQ-028 SHIFT_TYPE SHALL remain in the shared package; a new constant POLYSHIFT_MAX_STEP = 7 and the FSM state enum SHALL be added there.
REQ-029 SHALL instantiate exactly one existing polyshift_r as the datapath sub-module; all other logic is local registers and the FSM.

Verification
REQ-030 W=16, ARITH, D=0x8001, n=15 -> 3 SHIFT cycles; rsp_valid_o on cycle 3 after acceptance; d_o=0xFFFF.
REQ-031 W=16, ROR, D=0x0001, n=9 -> 2 SHIFT cycles; d_o=0x0080.
REQ-032 W=16, RCR, D=0x0000, C=0x7FFF, n=10 -> d_o=0xFFC0 after 2 cycles (intermediate D=0xFE00, C=0x00FF).
REQ-033 W=16, LOGIC, D=0xABCD, n=0 -> 1 SHIFT cycle; d_o=0xABCD; rsp_ready_i held low 5 cycles -> d_o stable, req_ready_o=0, a new req_valid_i is ignored.
REQ-034 Assert rst_n_i low in the 2nd SHIFT cycle of an n=15 request -> all outputs 0 immediately; after release req_ready_o=1 and no rsp_valid_o pulse.
REQ-035 Random sweep of all types x n=0..15 x random D/C with random rsp_ready_i gaps -> every d_o matches the REQ-020 model; latency matches REQ-019.
